// File: rtl/instr_loader.sv
// instr_loader: packs a host byte stream into 9-bit words, writes instr memory from 0, then runs the core
// Define CHECKSUM_EN to require a trailing XOR checksum byte before the core is started.
module instr_loader #(
   parameter int D = 12,
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [7:0]   in_byte,
   output logic         in_ready,
   output logic         wr_en,
   output logic [D-1:0] wr_addr,
   output logic [W-1:0] wr_data,
   output logic         req,
   input  logic         done,
   output logic         busy,
   output logic         load_err,
   output logic [D:0]   prog_len
);
`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {LEN_HI, LEN_LO, INS_HI, INS_LO, CHK, RUN} state_t;
`else
   typedef enum logic [2:0] {LEN_HI, LEN_LO, INS_HI, INS_LO, RUN} state_t;
`endif
   localparam logic [16:0] max_words = 17'(2 ** D);
   state_t       state;
   logic [7:0]   len_hi;
   logic         hi_bit;
   logic [D-1:0] cnt;
   logic         take, last;
   logic [16:0]  n;
`ifdef CHECKSUM_EN
   logic [7:0]   csum;
`endif
   assign take = in_valid & in_ready;
   assign n    = {1'b0, len_hi, in_byte};
   assign last = {1'b0, cnt} == prog_len - (D+1)'(1);
   // outputs are registered from the next state, so in_ready/busy follow the FSM by one edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= LEN_HI;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         req      <= 1'b0;
         load_err <= 1'b0;
         prog_len <= '0;
         cnt      <= '0;
         len_hi   <= '0;
         hi_bit   <= 1'b0;
`ifdef CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         wr_en    <= 1'b0;
         load_err <= 1'b0;
         case (state)
            LEN_HI: begin
               in_ready <= 1'b1;
               busy     <= 1'b0;
               if (take) begin
                  len_hi <= in_byte;
                  busy   <= 1'b1;
                  state  <= LEN_LO;
               end
            end
            LEN_LO: if (take) begin
               if (n == '0 || n > max_words) begin
                  load_err <= 1'b1;
                  busy     <= 1'b0;
                  state    <= LEN_HI;
               end else begin
                  prog_len <= n[D:0];
                  cnt      <= '0;
`ifdef CHECKSUM_EN
                  csum     <= '0;
`endif
                  state    <= INS_HI;
               end
            end
            INS_HI: if (take) begin
               if (|in_byte[7:1]) begin
                  load_err <= 1'b1;
                  busy     <= 1'b0;
                  state    <= LEN_HI;
               end else begin
                  hi_bit <= in_byte[0];
`ifdef CHECKSUM_EN
                  csum   <= csum ^ in_byte;
`endif
                  state  <= INS_LO;
               end
            end
            INS_LO: if (take) begin
               wr_en   <= 1'b1;
               wr_addr <= cnt;
               wr_data <= {hi_bit, in_byte};
               cnt     <= cnt + D'(1);
`ifdef CHECKSUM_EN
               csum    <= csum ^ in_byte;
               state   <= last ? CHK : INS_HI;
`else
               in_ready <= !last;
               state    <= last ? RUN : INS_HI;
`endif
            end
`ifdef CHECKSUM_EN
            CHK: if (take) begin
               if (in_byte == csum) begin
                  in_ready <= 1'b0;
                  state    <= RUN;
               end else begin
                  load_err <= 1'b1;
                  busy     <= 1'b0;
                  state    <= LEN_HI;
               end
            end
`endif
            RUN: begin
               // done only counts once req has been visible for at least one cycle
               if (req && done) begin
                  req      <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= LEN_HI;
               end else begin
                  req <= 1'b1;
               end
            end
            default: state <= LEN_HI;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized byte streams against a stream-level model; a monitor scoreboards writes, errors and req
module tb_instr_loader;
   localparam int D = 12;
   localparam int W = 9;
   logic         clk = 1'b0;
   logic         reset, in_valid, done;
   logic [7:0]   in_byte;
   logic         in_ready, wr_en, req, busy, load_err;
   logic [D-1:0] wr_addr;
   logic [W-1:0] wr_data;
   logic [D:0]   prog_len;
   typedef struct { int kind; int addr; int data; } ev_t;
   ev_t        exp_q[$];
   logic [7:0] stim[$];
   int         total = 0;
   int         bad = 0;
   bit         stall_en = 0;
   bit         req_q = 0;
   bit         wr_q = 0;

   instr_loader #(.D(D), .W(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .req(req), .done(done),
      .busy(busy), .load_err(load_err), .prog_len(prog_len)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, want);
      end
   endtask

   task automatic push_ev(input int k, input int a, input int d);
      ev_t e;
      e.kind = k; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   // kind 0 = write(addr,data), 1 = load_err, 2 = req rise (data = prog_len)
   task automatic expect_ev(input int k, input int a, input int d);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL event got kind=%0d addr=%0h data=%0h want none", k, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.addr != a || e.data != d) begin
            bad++;
            $display("FAIL event got kind=%0d addr=%0h data=%0h want kind=%0d addr=%0h data=%0h",
                     k, a, d, e.kind, e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (wr_en && load_err) check("wr_err_excl", 1, 0);
         if (wr_en) expect_ev(0, int'(wr_addr), int'(wr_data));
         if (load_err) expect_ev(1, 0, 0);
         if (req && !req_q) begin
            expect_ev(2, 0, int'(prog_len));
`ifndef CHECKSUM_EN
            check("req_after_last_wr", int'(wr_q), 1);
`endif
         end
         req_q = req;
         wr_q  = wr_en;
      end else begin
         req_q = 0;
         wr_q  = 0;
      end
   end

   // Spec-level parse of stim[0..limit-1]; returns bytes the loader consumes and whether it reaches RUN
   task automatic model(input int limit, output int used, output bit runs);
      int n;
      logic [7:0] h, l, x;
      runs = 0;
      used = limit;
      n = {stim[0], stim[1]};
      if (n == 0 || n > 2 ** D) begin
         push_ev(1, 0, 0);
         used = 2;
         return;
      end
      x = 0;
      for (int i = 0; i < n; i++) begin
         if (2 + 2 * i >= limit) return;
         h = stim[2 + 2 * i];
         if (h[7:1] != 0) begin
            push_ev(1, 0, 0);
            used = 3 + 2 * i;
            return;
         end
         if (3 + 2 * i >= limit) return;
         l = stim[3 + 2 * i];
         push_ev(0, i, {h[0], l});
         x = x ^ h ^ l;
      end
`ifdef CHECKSUM_EN
      if (2 + 2 * n >= limit) return;
      used = 3 + 2 * n;
      if (stim[2 + 2 * n] != x) begin
         push_ev(1, 0, 0);
         return;
      end
`else
      used = 2 + 2 * n;
`endif
      push_ev(2, 0, n);
      runs = 1;
   endtask

   task automatic send(input logic [7:0] b);
      int t;
      if (stall_en && $urandom_range(0, 2) == 0) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_byte  = b;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("in_ready_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic finish_run();
      int t;
      t = 0;
      while (!req && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("req_up", int'(req), 1);
      check("in_ready_run", int'(in_ready), 0);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("req_drop", int'(req), 0);
      check("in_ready_after_run", int'(in_ready), 1);
      check("busy_after_run", int'(busy), 0);
   endtask

   task automatic play(input int n, input bit runs, input bit early);
      if (early) done = 1'b1;
      for (int i = 0; i < n; i++) send(stim[i]);
      in_valid = 1'b0;
      if (runs) finish_run();
      else repeat (3) @(negedge clk);
      done = 1'b0;
   endtask

   task automatic play_model(input bit early);
      int used;
      bit runs;
      model(stim.size(), used, runs);
      play(used, runs, early);
   endtask

   // mode 0 good, 1 corrupt one HI byte, 2 corrupt checksum (only meaningful with CHECKSUM_EN)
   task automatic make_rand(input int n, input int mode);
      logic [8:0] mc;
      logic [7:0] h, x;
      int k;
      stim.delete();
      stim.push_back(8'(n >> 8));
      stim.push_back(8'(n));
      x = 0;
      k = $urandom_range(0, n - 1);
      for (int i = 0; i < n; i++) begin
         mc = 9'($urandom);
         h = {7'b0, mc[8]};
         if (mode == 1 && i == k) h = {7'($urandom_range(1, 127)), mc[8]};
         stim.push_back(h);
         stim.push_back(mc[7:0]);
         x = x ^ h ^ mc[7:0];
      end
`ifdef CHECKSUM_EN
      stim.push_back(mode == 2 ? x ^ 8'($urandom_range(1, 255)) : x);
`endif
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"}, int'(in_ready), 0);
      check({tag, "_wr_en"}, int'(wr_en), 0);
      check({tag, "_wr_addr"}, int'(wr_addr), 0);
      check({tag, "_wr_data"}, int'(wr_data), 0);
      check({tag, "_req"}, int'(req), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_load_err"}, int'(load_err), 0);
      check({tag, "_prog_len"}, int'(prog_len), 0);
   endtask

   initial begin
      int used;
      bit runs;
      reset = 1'b0; in_valid = 1'b0; in_byte = 8'h00; done = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("rst");
      reset = 1'b1;
      #1 check("in_ready_pre_edge", int'(in_ready), 0);
      @(negedge clk);
      check("in_ready_post_rst", int'(in_ready), 1);
      check("busy_idle", int'(busy), 0);

      stim = '{8'h00, 8'h03, 8'h01, 8'h2A, 8'h00, 8'h05, 8'h01, 8'hFF};
`ifdef CHECKSUM_EN
      stim.push_back(8'hD0);
`endif
      push_ev(0, 0, 'h12A); push_ev(0, 1, 'h005); push_ev(0, 2, 'h1FF); push_ev(2, 0, 3);
      play(stim.size(), 1, 0);
      check("prog_len_kept", int'(prog_len), 3);

      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      check("idle_done_req", int'(req), 0);
      check("idle_done_busy", int'(busy), 0);
      check("idle_done_ready", int'(in_ready), 1);

      stim = '{8'h00, 8'h02, 8'h02, 8'h11};
      push_ev(1, 0, 0);
      play(3, 0, 0);
      check("busy_after_err", int'(busy), 0);
      make_rand(2, 0);
      play_model(0);

      stim = '{8'h00, 8'h00};
      push_ev(1, 0, 0);
      play(2, 0, 0);
      stim = '{8'h10, 8'h01};
      push_ev(1, 0, 0);
      play(2, 0, 0);
      check("req_after_bad_hdr", int'(req), 0);

      stall_en = 1;
      make_rand(4, 0);
      model(6, used, runs);
      play(used, runs, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check_zero("abort");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("in_ready_after_abort", int'(in_ready), 1);
      make_rand(2, 0);
      play_model(0);

      for (int it = 0; it < 24; it++) begin
         make_rand($urandom_range(1, 6), $urandom_range(0, 2));
         play_model(1'($urandom_range(0, 1)));
      end
      stall_en = 0;

`ifdef CHECKSUM_EN
      stim = '{8'h00, 8'h01, 8'h01, 8'h2A, 8'h2B};
      push_ev(0, 0, 'h12A); push_ev(2, 0, 1);
      play(5, 1, 0);
      stim = '{8'h00, 8'h01, 8'h01, 8'h2A, 8'h2C};
      push_ev(0, 0, 'h12A); push_ev(1, 0, 0);
      play(5, 0, 0);
      check("req_after_bad_csum", int'(req), 0);
`endif

      repeat (3) @(negedge clk);
      check("events_left", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
